// File: rtl/ame_equation_builder.sv
// Affine ME equation builder: accumulates the 6x6 normal matrix A and vector B from a per-pixel
// gradient stream. Define AME_EQUATION_BUILDER_SAT_EN for saturating accumulation and sat_o.
module ame_equation_builder #(
    parameter int COMP_DATA_BITS = 64,
    parameter int GRAD_BITS      = 16,
    parameter int POS_BITS       = 7
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                affine_param6_i,
    input  logic                                samp_valid_i,
    output logic                                samp_ready_o,
    input  logic                                samp_last_i,
    input  logic signed [GRAD_BITS-1:0]         samp_grad_x_i,
    input  logic signed [GRAD_BITS-1:0]         samp_grad_y_i,
    input  logic        [POS_BITS-1:0]          samp_pos_x_i,
    input  logic        [POS_BITS-1:0]          samp_pos_y_i,
    input  logic signed [GRAD_BITS-1:0]         samp_diff_i,
    output logic                                comp_init_o,
    input  logic                                comp_done_i,
    output logic                                affine_param6_o,
    output logic [5:0][6:0][COMP_DATA_BITS-1:0] comp_data_o
`ifdef AME_EQUATION_BUILDER_SAT_EN
    ,
    output logic                                sat_o
`endif
);
    localparam int CW   = GRAD_BITS + POS_BITS + 2;
    localparam int PW   = 2 * CW;
    localparam int NACC = 27;

    // Packed upper-triangle index of A; B[i] lives at 21 + i.
    function automatic int a_idx(input int i, input int j);
        return i * 6 - (i * (i - 1)) / 2 + (j - i);
    endfunction

    typedef enum logic [2:0] {ST_IDLE, ST_ACCUM, ST_DRAIN, ST_ISSUE, ST_WAIT} state_t;

    state_t     state_reg;
    logic [1:0] drain_cnt_reg;
    logic       hs;
    logic       first_hs;

    assign hs       = samp_valid_i & samp_ready_o;
    assign first_hs = hs & (state_reg == ST_IDLE);

    // DRAIN spans four cycles so comp_init_o lands four edges after the last accepted sample.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg       <= ST_IDLE;
            drain_cnt_reg   <= '0;
            samp_ready_o    <= 1'b0;
            comp_init_o     <= 1'b0;
            affine_param6_o <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    samp_ready_o <= 1'b1;
                    if (hs) begin
                        affine_param6_o <= affine_param6_i;
                        if (samp_last_i) begin
                            state_reg     <= ST_DRAIN;
                            samp_ready_o  <= 1'b0;
                            drain_cnt_reg <= '0;
                        end else begin
                            state_reg <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (hs && samp_last_i) begin
                        state_reg     <= ST_DRAIN;
                        samp_ready_o  <= 1'b0;
                        drain_cnt_reg <= '0;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_reg <= drain_cnt_reg + 2'd1;
                    if (drain_cnt_reg == 2'd3) begin
                        state_reg   <= ST_ISSUE;
                        comp_init_o <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    comp_init_o <= 1'b0;
                    state_reg   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (comp_done_i) begin
                        state_reg    <= ST_IDLE;
                        samp_ready_o <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // The model bit is taken live on the opening sample, then from the latched copy.
    logic                 mode6;
    logic signed [CW-1:0] gx_w, gy_w, x_w, y_w;
    logic signed [CW-1:0] c_next [6];

    assign mode6 = (state_reg == ST_IDLE) ? affine_param6_i : affine_param6_o;
    assign gx_w  = {{(CW-GRAD_BITS){samp_grad_x_i[GRAD_BITS-1]}}, samp_grad_x_i};
    assign gy_w  = {{(CW-GRAD_BITS){samp_grad_y_i[GRAD_BITS-1]}}, samp_grad_y_i};
    assign x_w   = {{(CW-POS_BITS){1'b0}}, samp_pos_x_i};
    assign y_w   = {{(CW-POS_BITS){1'b0}}, samp_pos_y_i};

    always_comb begin
        if (mode6) begin
            c_next[0] = gx_w;
            c_next[1] = gx_w * x_w;
            c_next[2] = gy_w;
            c_next[3] = gy_w * x_w;
            c_next[4] = gx_w * y_w;
            c_next[5] = gy_w * y_w;
        end else begin
            c_next[0] = '0;
            c_next[1] = '0;
            c_next[2] = gx_w;
            c_next[3] = gx_w * x_w + gy_w * y_w;
            c_next[4] = gy_w;
            c_next[5] = gx_w * y_w - gy_w * x_w;
        end
    end

    logic signed [CW-1:0]        c_reg [6];
    logic signed [GRAD_BITS-1:0] d_reg;
    logic                        s1_valid_reg;
    logic                        s2_valid_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            d_reg        <= '0;
            for (int k = 0; k < 6; k++) c_reg[k] <= '0;
        end else begin
            s1_valid_reg <= hs;
            s2_valid_reg <= s1_valid_reg;
            d_reg        <= samp_diff_i;
            for (int k = 0; k < 6; k++) c_reg[k] <= c_next[k];
        end
    end

    logic signed [PW-1:0]             c_x [6];
    logic signed [PW-1:0]             d_x;
    logic signed [COMP_DATA_BITS-1:0] acc_w [NACC];

    assign d_x = {{(PW-GRAD_BITS){d_reg[GRAD_BITS-1]}}, d_reg};

`ifdef AME_EQUATION_BUILDER_SAT_EN
    localparam int SW = ((PW > COMP_DATA_BITS) ? PW : COMP_DATA_BITS) + 1;
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-COMP_DATA_BITS+1){1'b0}}, {(COMP_DATA_BITS-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-COMP_DATA_BITS+1){1'b1}}, {(COMP_DATA_BITS-1){1'b0}}};
    logic [NACC-1:0] clamp_w;
`endif

    genvar gi, gj;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_cx
            assign c_x[gi] = {{(PW-CW){c_reg[gi][CW-1]}}, c_reg[gi]};
        end

        for (gi = 0; gi < 6; gi++) begin : g_row
            for (gj = gi; gj < 7; gj++) begin : g_col
                localparam int K = (gj == 6) ? 21 + gi : a_idx(gi, gj);
                logic signed [PW-1:0]             prod_reg;
                logic signed [COMP_DATA_BITS-1:0] acc_reg;
                logic signed [COMP_DATA_BITS-1:0] acc_next;

                if (gj == 6) begin : g_b
                    always_ff @(posedge clk_i or negedge rst_n_i) begin
                        if (!rst_n_i) prod_reg <= '0;
                        else          prod_reg <= c_x[gi] * d_x;
                    end
                end else begin : g_a
                    always_ff @(posedge clk_i or negedge rst_n_i) begin
                        if (!rst_n_i) prod_reg <= '0;
                        else          prod_reg <= c_x[gi] * c_x[gj];
                    end
                end

`ifdef AME_EQUATION_BUILDER_SAT_EN
                logic signed [SW-1:0] acc_x, prod_x, sum_w;
                assign acc_x      = {{(SW-COMP_DATA_BITS){acc_reg[COMP_DATA_BITS-1]}}, acc_reg};
                assign prod_x     = {{(SW-PW){prod_reg[PW-1]}}, prod_reg};
                assign sum_w      = acc_x + prod_x;
                assign clamp_w[K] = (sum_w > SAT_MAX) || (sum_w < SAT_MIN);
                assign acc_next   = (sum_w > SAT_MAX) ? {1'b0, {(COMP_DATA_BITS-1){1'b1}}} :
                                    (sum_w < SAT_MIN) ? {1'b1, {(COMP_DATA_BITS-1){1'b0}}} :
                                    sum_w[COMP_DATA_BITS-1:0];
`else
                logic signed [COMP_DATA_BITS-1:0] prod_c;
                if (PW >= COMP_DATA_BITS) begin : g_trunc
                    assign prod_c = prod_reg[COMP_DATA_BITS-1:0];
                end else begin : g_sext
                    assign prod_c = {{(COMP_DATA_BITS-PW){prod_reg[PW-1]}}, prod_reg};
                end
                assign acc_next = acc_reg + prod_c;
`endif

                always_ff @(posedge clk_i or negedge rst_n_i) begin
                    if (!rst_n_i)          acc_reg <= '0;
                    else if (first_hs)     acc_reg <= '0;
                    else if (s2_valid_reg) acc_reg <= acc_next;
                end
                assign acc_w[K] = acc_reg;
            end
        end

        // A is symmetric: lower-triangle entries mirror the stored upper triangle.
        for (gi = 0; gi < 6; gi++) begin : g_out_row
            for (gj = 0; gj < 6; gj++) begin : g_out_col
                localparam int K = (gi <= gj) ? a_idx(gi, gj) : a_idx(gj, gi);
                assign comp_data_o[gi][gj] = acc_w[K];
            end
            assign comp_data_o[gi][6] = acc_w[21+gi];
        end
    endgenerate

`ifdef AME_EQUATION_BUILDER_SAT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                          sat_o <= 1'b0;
        else if (first_hs)                     sat_o <= 1'b0;
        else if (s2_valid_reg && (|clamp_w))   sat_o <= 1'b1;
    end
`endif
endmodule
